// File: rtl/picorv32_wb_pkg.sv
// Shared types and constants for the picorv32 native-port to Wishbone classic bridge.
package picorv32_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } bridge_state_e;

    // Byte-select pattern used for reads on the default 32-bit data path.
    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    // Default abort threshold and the counter width that goes with it.
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
    localparam int TIMEOUT_W              = $clog2(DEFAULT_TIMEOUT_CYCLES + 1);

    // Width of a counter that must be able to hold values 0..cycles.
    function automatic int timeout_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/picorv32_wb_bridge_watchdog.sv
// Bus-cycle watchdog for the picorv32 Wishbone bridge (module wb_timeout_watchdog).
// Only instantiated when PICORV_WB_TIMEOUT_EN is defined.
// The counter restarts on clear and advances on each tick. 'expired' fires
// combinationally on the tick that would complete CYCLES ticks.
module wb_timeout_watchdog
    import picorv32_wb_pkg::*;
#(
    parameter int CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int W      = timeout_width(CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    logic [W-1:0] count;

    // Count consecutive ticks since the last clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign expired = tick && (count == W'(CYCLES - 1));

endmodule

// File: rtl/picorv32_wb_bridge.sv
// picorv32 native memory port -> one Wishbone classic master cycle per request.
// Holds exactly one outstanding transfer.
// The optional bus timeout is enabled by defining PICORV_WB_TIMEOUT_EN.
module picorv32_wb_bridge
    import picorv32_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic                    mem_valid,
    input  logic                    mem_instr,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_ready,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i,
    output logic                    wb_instr_o,
    output logic                    bus_err_o
);

    localparam int SEL_W = DATA_WIDTH / 8;

    bridge_state_e state;
    bridge_state_e state_next;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [SEL_W-1:0]      sel_r;
    logic                  we_r;
    logic                  instr_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    logic accept;
    logic read_capture;
    logic timeout_abort;
    logic timeout_hit;
    logic in_bus;
    logic ready;

`ifdef PICORV_WB_TIMEOUT_EN
    logic err_r;

    // The counter stays cleared while idle, so it starts from zero on BUS entry.
    // It only advances on BUS cycles that see no ack, which is why an ack
    // arriving in the expiry cycle wins.
    wb_timeout_watchdog #(
        .CYCLES (TIMEOUT_CYCLES),
        .W      (timeout_width(TIMEOUT_CYCLES))
    ) u_watchdog (
        .clk     (clk_core),
        .rst     (rst_core),
        .clear   (state == IDLE),
        .tick    ((state == BUS) && !wb_ack_i),
        .expired (timeout_hit)
    );

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            err_r <= 1'b0;
        end else if (timeout_abort) begin
            err_r <= 1'b1;
        end
    end

    assign bus_err_o = err_r;
`else
    assign timeout_hit = 1'b0;
    assign bus_err_o   = 1'b0;
`endif

    // State register; async reset drops cyc/stb immediately because they decode from it.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> BUS on request, BUS -> RESP on ack/abort, RESP -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    state_next = BUS;
                end else begin
                    state_next = IDLE;
                end
            end
            BUS: begin
                if (wb_ack_i || timeout_hit) begin
                    state_next = RESP;
                end else begin
                    state_next = BUS;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and capture-enable decode from the registered state.
    // mem_ready is qualified by mem_valid so that a request the core has
    // withdrawn does not complete.
    always_comb begin
        accept        = (state == IDLE) && mem_valid;
        in_bus        = (state == BUS);
        read_capture  = in_bus && wb_ack_i && !we_r;
        timeout_abort = in_bus && !wb_ack_i && timeout_hit;
        ready         = (state == RESP) && mem_valid;
    end

    // Latch the request; these values stay stable for the whole Wishbone cycle.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            addr_r  <= '0;
            wdata_r <= '0;
            sel_r   <= '0;
            we_r    <= 1'b0;
            instr_r <= 1'b0;
        end else if (accept) begin
            addr_r  <= mem_addr;
            wdata_r <= mem_wdata;
            we_r    <= |mem_wstrb;
            sel_r   <= (|mem_wstrb) ? mem_wstrb : {SEL_W{1'b1}};
            instr_r <= mem_instr;
        end
    end

    // Read data changes only on a read ack, or is forced to zero on a timeout abort.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            rdata_r <= '0;
        end else if (read_capture) begin
            rdata_r <= wb_data_i;
        end else if (timeout_abort) begin
            rdata_r <= '0;
        end
    end

    assign wb_cyc_o   = in_bus;
    assign wb_stb_o   = in_bus;
    assign wb_we_o    = we_r;
    assign wb_sel_o   = sel_r;
    assign wb_addr_o  = addr_r;
    assign wb_data_o  = wdata_r;
    assign wb_instr_o = instr_r;
    assign mem_rdata  = rdata_r;
    assign mem_ready  = ready;

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Directed self-checking bench for picorv32_wb_bridge.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_picorv32_wb_bridge;

    logic        clk_core;
    logic        rst_core;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        wb_instr_o;
    logic        bus_err_o;

    int n_checks = 0;
    int n_errors = 0;

    picorv32_wb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_core   (clk_core),
        .rst_core   (rst_core),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_data_i  (wb_data_i),
        .wb_ack_i   (wb_ack_i),
        .wb_instr_o (wb_instr_o),
        .bus_err_o  (bus_err_o)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_core);
    endtask

    task automatic request(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic ins);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_instr = ins;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_core  = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        wb_data_i = 32'h0;
        wb_ack_i  = 1'b0;
        step();
        step();

        // Reset state
        check("rst_cyc",   {31'd0, wb_cyc_o},  32'd0);
        check("rst_stb",   {31'd0, wb_stb_o},  32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata,          32'd0);
        check("rst_addr",  wb_addr_o,          32'd0);
        check("rst_err",   {31'd0, bus_err_o}, 32'd0);
        rst_core = 1'b0;
        step();

        // Read, ack one cycle after cyc rises
        request(32'h100, 32'h0, 4'h0, 1'b0);
        step();
        check("rd_cyc",   {31'd0, wb_cyc_o},  32'd1);
        check("rd_stb",   {31'd0, wb_stb_o},  32'd1);
        check("rd_we",    {31'd0, wb_we_o},   32'd0);
        check("rd_sel",   {28'd0, wb_sel_o},  32'hF);
        check("rd_addr",  wb_addr_o,          32'h100);
        check("rd_noready", {31'd0, mem_ready}, 32'd0);
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h12345678;
        step();
        check("rd_ready", {31'd0, mem_ready}, 32'd1);
        check("rd_rdata", mem_rdata,          32'h12345678);
        check("rd_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        mem_valid = 1'b0;
        wb_ack_i  = 1'b0;
        wb_data_i = 32'h0BAD0BAD;
        step();
        check("rd_ready_pulse", {31'd0, mem_ready}, 32'd0);

        // Byte write
        request(32'h2000, 32'hAABBCCDD, 4'h4, 1'b0);
        step();
        check("wr_we",   {31'd0, wb_we_o},  32'd1);
        check("wr_sel",  {28'd0, wb_sel_o}, 32'h4);
        check("wr_data", wb_data_o,         32'hAABBCCDD);
        check("wr_addr", wb_addr_o,         32'h2000);
        wb_ack_i  = 1'b1;
        wb_data_i = 32'hDEADBEEF;
        step();
        check("wr_ready", {31'd0, mem_ready}, 32'd1);
        check("wr_rdata_hold", mem_rdata,     32'h12345678);
        mem_valid = 1'b0;
        wb_ack_i  = 1'b0;
        step();

        // Stray ack while idle is ignored
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h99999999;
        step();
        step();
        check("idle_ack_ready", {31'd0, mem_ready}, 32'd0);
        check("idle_ack_cyc",   {31'd0, wb_cyc_o},  32'd0);
        check("idle_ack_rdata", mem_rdata,          32'h12345678);
        wb_ack_i = 1'b0;
        step();

        // Ack delayed five cycles
        request(32'h300, 32'h0, 4'h0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("dly_cyc",   {31'd0, wb_cyc_o},  32'd1);
            check("dly_stb",   {31'd0, wb_stb_o},  32'd1);
            check("dly_addr",  wb_addr_o,          32'h300);
            check("dly_ready", {31'd0, mem_ready}, 32'd0);
            if (i == 4) begin
                wb_ack_i  = 1'b1;
                wb_data_i = 32'hCAFEF00D;
            end
            step();
        end
        check("dly_ready_hi", {31'd0, mem_ready}, 32'd1);
        check("dly_rdata",    mem_rdata,          32'hCAFEF00D);
        mem_valid = 1'b0;
        wb_ack_i  = 1'b0;
        step();
        check("dly_ready_lo", {31'd0, mem_ready}, 32'd0);
        check("dly_cyc_lo",   {31'd0, wb_cyc_o},  32'd0);

        // Back-to-back fetch then load
        request(32'h0, 32'h0, 4'h0, 1'b1);
        step();
        check("b2b_instr1", {31'd0, wb_instr_o}, 32'd1);
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h00000013;
        step();
        check("b2b_ready1", {31'd0, mem_ready}, 32'd1);
        check("b2b_rdata1", mem_rdata,          32'h00000013);
        request(32'h400, 32'h0, 4'h0, 1'b0);
        wb_ack_i = 1'b0;
        step();
        check("b2b_gap_cyc",   {31'd0, wb_cyc_o},  32'd0);
        check("b2b_gap_ready", {31'd0, mem_ready}, 32'd0);
        step();
        check("b2b_cyc2",   {31'd0, wb_cyc_o},   32'd1);
        check("b2b_instr2", {31'd0, wb_instr_o}, 32'd0);
        check("b2b_addr2",  wb_addr_o,           32'h400);
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h55AA55AA;
        step();
        check("b2b_ready2", {31'd0, mem_ready}, 32'd1);
        check("b2b_rdata2", mem_rdata,          32'h55AA55AA);
        mem_valid = 1'b0;
        wb_ack_i  = 1'b0;
        step();

        // Core withdraws the request during BUS: cycle completes, ready suppressed
        request(32'h500, 32'h0, 4'h0, 1'b0);
        step();
        mem_valid = 1'b0;
        step();
        check("wd_cyc_hold", {31'd0, wb_cyc_o}, 32'd1);
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h11112222;
        step();
        check("wd_ready", {31'd0, mem_ready}, 32'd0);
        check("wd_rdata", mem_rdata,          32'h11112222);
        check("wd_cyc",   {31'd0, wb_cyc_o},  32'd0);
        wb_ack_i = 1'b0;
        step();

        // Reset asserted in BUS drops cyc/stb without a clock edge
        request(32'h600, 32'h0, 4'h0, 1'b0);
        step();
        check("mr_cyc_pre", {31'd0, wb_cyc_o}, 32'd1);
        #2 rst_core = 1'b1;
        #1;
        check("mr_cyc",   {31'd0, wb_cyc_o},  32'd0);
        check("mr_stb",   {31'd0, wb_stb_o},  32'd0);
        check("mr_ready", {31'd0, mem_ready}, 32'd0);
        check("mr_rdata", mem_rdata,          32'd0);
        #1 rst_core = 1'b0;
        step();
        check("mr_restart_cyc",  {31'd0, wb_cyc_o}, 32'd1);
        check("mr_restart_addr", wb_addr_o,         32'h600);
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h77778888;
        step();
        check("mr_ready2", {31'd0, mem_ready}, 32'd1);
        check("mr_rdata2", mem_rdata,          32'h77778888);
        mem_valid = 1'b0;
        wb_ack_i  = 1'b0;
        step();

        // Missing ack
        request(32'h700, 32'h0, 4'h0, 1'b0);
        step();
`ifdef PICORV_WB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check("to_cyc", {31'd0, wb_cyc_o}, 32'd1);
            step();
        end
        check("to_cyc_drop", {31'd0, wb_cyc_o},  32'd0);
        check("to_ready",    {31'd0, mem_ready}, 32'd1);
        check("to_rdata",    mem_rdata,          32'd0);
        check("to_err",      {31'd0, bus_err_o}, 32'd1);
        mem_valid = 1'b0;
        step();
        step();
        check("to_err_sticky", {31'd0, bus_err_o}, 32'd1);
        check("to_ready_lo",   {31'd0, mem_ready}, 32'd0);
`else
        for (int i = 0; i < 12; i++) begin
            check("nto_cyc", {31'd0, wb_cyc_o},  32'd1);
            check("nto_err", {31'd0, bus_err_o}, 32'd0);
            step();
        end
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h0F0F0F0F;
        step();
        check("nto_ready", {31'd0, mem_ready}, 32'd1);
        check("nto_rdata", mem_rdata,          32'h0F0F0F0F);
        mem_valid = 1'b0;
        wb_ack_i  = 1'b0;
        step();
        check("nto_err_end", {31'd0, bus_err_o}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
